// File: rtl/sdr_wr_burst_feeder.sv
// Write-burst sequencer: pops FWFT write words and drives DATAIN/DM/DQ_OE,
// with DM one cycle ahead of DATAIN so the data path's DQM register lines them up.
module sdr_wr_burst_feeder #(
    parameter int DSIZE  = 32,
    parameter int BL_MAX = 8,
    parameter int CNT_W  = 4
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 WR_START,
    input  logic [CNT_W-1:0]     WR_LEN,
    input  logic                 WR_ABORT,
    input  logic [DSIZE-1:0]     FIFO_DATA,
    input  logic                 FIFO_EMPTY,
    output logic                 FIFO_RD,
    output logic [DSIZE-1:0]     DATAIN,
    output logic [DSIZE/8-1:0]   DM,
    output logic                 DQ_OE,
    output logic                 BUSY,
    output logic                 UNDERRUN,
    input  logic                 UNDERRUN_CLR
);

    localparam logic [CNT_W-1:0] LEN_CAP = CNT_W'(BL_MAX);

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        DRAIN1,
        DRAIN2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   remaining;
    logic [DSIZE-1:0]   stage1;
    logic               stage1_valid;

    // Pop only on a real beat; an aborting cycle or an empty FIFO never pops.
    assign FIFO_RD = (state == BURST) && !WR_ABORT && !FIFO_EMPTY;
    assign BUSY    = (state != IDLE);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state        <= IDLE;
            remaining    <= '0;
            stage1       <= '0;
            stage1_valid <= 1'b0;
            DATAIN       <= '0;
            DM           <= '1;
            DQ_OE        <= 1'b0;
            UNDERRUN     <= 1'b0;
        end else begin
            // Second stage: data and output enable follow DM by one cycle.
            DATAIN       <= stage1;
            DQ_OE        <= stage1_valid;

            DM           <= '1;
            stage1       <= '0;
            stage1_valid <= 1'b0;

            if (UNDERRUN_CLR) begin
                UNDERRUN <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (WR_START && (WR_LEN != '0)) begin
                        remaining <= (WR_LEN > LEN_CAP) ? LEN_CAP : WR_LEN;
                        state     <= BURST;
                    end
                end

                BURST: begin
                    if (WR_ABORT) begin
                        remaining <= '0;
                        state     <= DRAIN1;
                    end else begin
                        // An empty FIFO still consumes the beat, but the slot is masked.
                        stage1_valid <= 1'b1;
                        remaining    <= remaining - CNT_W'(1);
                        if (FIFO_EMPTY) begin
                            UNDERRUN <= 1'b1;
                        end else begin
                            DM     <= '0;
                            stage1 <= FIFO_DATA;
                        end
                        if (remaining == CNT_W'(1)) begin
                            state <= DRAIN1;
                        end
                    end
                end

                DRAIN1: begin
                    state <= DRAIN2;
                end

                DRAIN2: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdr_wr_burst_feeder.sv
// Self-checking bench for sdr_wr_burst_feeder: table-driven bursts with a beat
// scoreboard, plus hand-written timing, underrun and reset sequences.
module tb_sdr_wr_burst_feeder;

    localparam int DSIZE  = 32;
    localparam int BL_MAX = 8;
    localparam int CNT_W  = 4;
    localparam int MW     = DSIZE / 8;
    localparam int NWIN   = 20;
    localparam int NVEC   = 14;

    logic               CLK = 1'b0;
    logic               RESET_N = 1'b1;
    logic               WR_START = 1'b0;
    logic [CNT_W-1:0]   WR_LEN = '0;
    logic               WR_ABORT = 1'b0;
    logic [DSIZE-1:0]   FIFO_DATA = '0;
    logic               FIFO_EMPTY = 1'b1;
    logic               FIFO_RD;
    logic [DSIZE-1:0]   DATAIN;
    logic [MW-1:0]      DM;
    logic               DQ_OE;
    logic               BUSY;
    logic               UNDERRUN;
    logic               UNDERRUN_CLR = 1'b0;

    sdr_wr_burst_feeder #(
        .DSIZE  (DSIZE),
        .BL_MAX (BL_MAX),
        .CNT_W  (CNT_W)
    ) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .WR_START     (WR_START),
        .WR_LEN       (WR_LEN),
        .WR_ABORT     (WR_ABORT),
        .FIFO_DATA    (FIFO_DATA),
        .FIFO_EMPTY   (FIFO_EMPTY),
        .FIFO_RD      (FIFO_RD),
        .DATAIN       (DATAIN),
        .DM           (DM),
        .DQ_OE        (DQ_OE),
        .BUSY         (BUSY),
        .UNDERRUN     (UNDERRUN),
        .UNDERRUN_CLR (UNDERRUN_CLR)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [DSIZE-1:0] data;
        logic [MW-1:0]    dm;
    } beat_t;

    typedef struct {
        int          len;
        int          abort_at;
        logic [31:0] mask;
        int          clr_at;
        int          restart_at;
        int          exp_rd;
        logic        exp_und;
        int          exp_busy;
    } vec_t;

    beat_t              exp_q[$];
    logic [DSIZE-1:0]   fifo_q[$];
    logic               force_empty = 1'b0;
    int                 compared = 0;
    int                 mismatched = 0;

    logic               s_rd, s_oe, s_busy, s_und;
    logic [DSIZE-1:0]   s_data;
    logic [MW-1:0]      s_dm;
    logic [MW-1:0]      prev_dm = '1;

    logic               rec_rd[NWIN];
    logic               rec_oe[NWIN];
    logic               rec_busy[NWIN];
    logic               rec_und[NWIN];
    logic [MW-1:0]      rec_dm[NWIN];
    logic [DSIZE-1:0]   rec_data[NWIN];

    vec_t               vecs[NVEC];
    logic [DSIZE-1:0]   a_words[4];

    task automatic checkOutput(input string name, input logic [DSIZE-1:0] actual,
                               input logic [DSIZE-1:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
        end
    endtask

    task automatic updateFifoPins();
        FIFO_EMPTY = (fifo_q.size() == 0) || force_empty;
        FIFO_DATA  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    endtask

    // One clock: sample at the falling edge, score beats, pop the FIFO model after the rise.
    task automatic tick();
        beat_t b;
        logic [DSIZE-1:0] dummy;
        updateFifoPins();
        @(negedge CLK);
        s_rd   = FIFO_RD;
        s_oe   = DQ_OE;
        s_busy = BUSY;
        s_und  = UNDERRUN;
        s_data = DATAIN;
        s_dm   = DM;
        if (FIFO_EMPTY) checkOutput("fifo_rd_while_empty", DSIZE'(s_rd), '0);
        if (s_oe) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_beat: got DATAIN %h with DQ_OE=1, want no beat", s_data);
            end else begin
                b = exp_q.pop_front();
                checkOutput("beat_data", s_data, b.data);
                checkOutput("beat_dm", DSIZE'(prev_dm), DSIZE'(b.dm));
            end
        end
        prev_dm = s_dm;
        @(posedge CLK);
        #1;
        if (s_rd && fifo_q.size() != 0) dummy = fifo_q.pop_front();
    endtask

    task automatic prepVector(input int nwords, input logic use_a);
        UNDERRUN_CLR = 1'b1;
        tick();
        UNDERRUN_CLR = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        for (int i = 0; i < nwords; i++) begin
            if (use_a) fifo_q.push_back(a_words[i]);
            else       fifo_q.push_back($urandom());
        end
    endtask

    // Drives one burst scenario over a fixed window; the model queues the expected beats first.
    task automatic applyStimulus(input int len, input int abort_at, input logic [31:0] mask,
                                 input int clr_at, input int restart_at);
        logic [DSIZE-1:0] mf[$];
        beat_t b;
        int st, L, bc, c, nxt;
        mf = fifo_q;
        st = 0;
        for (int burst = 0; burst < 2; burst++) begin
            if (st >= 0) begin
                L  = (len > BL_MAX) ? BL_MAX : len;
                bc = 0;
                for (int i = 0; i < L; i++) begin
                    c  = st + 1 + i;
                    bc = i + 1;
                    if (c == abort_at) break;
                    if (mask[c]) begin
                        b.data = '0;
                        b.dm   = '1;
                    end else begin
                        b.data = mf.pop_front();
                        b.dm   = '0;
                    end
                    exp_q.push_back(b);
                end
                nxt = (len > 0) ? st + bc + 3 : st + 1;
                st  = (burst == 0 && restart_at > 0 && restart_at >= nxt) ? restart_at : -1;
            end
        end
        for (int r = 0; r < NWIN; r++) begin
            WR_START     = (r == 0) || (r == restart_at);
            WR_LEN       = CNT_W'(len);
            WR_ABORT     = (r == abort_at);
            UNDERRUN_CLR = (r == clr_at);
            force_empty  = mask[r];
            tick();
            rec_rd[r]   = s_rd;
            rec_oe[r]   = s_oe;
            rec_busy[r] = s_busy;
            rec_und[r]  = s_und;
            rec_dm[r]   = s_dm;
            rec_data[r] = s_data;
        end
        WR_START     = 1'b0;
        WR_LEN       = '0;
        WR_ABORT     = 1'b0;
        UNDERRUN_CLR = 1'b0;
        force_empty  = 1'b0;
        checkOutput("pending_beats", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish by 200000, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int rd_n, busy_n;
        logic exp_oe;

        for (int i = 0; i < 4; i++) a_words[i] = 32'hA0A0_0000 + DSIZE'(i);

        //             len abort mask       clr restart rd und busy
        vecs[0]  = '{4,  -1, 32'h0000_0000, -1, -1, 4, 1'b0, 6};
        vecs[1]  = '{4,  -1, 32'h0000_0004, -1, -1, 3, 1'b1, 6};
        vecs[2]  = '{0,  -1, 32'h0000_0000, -1, -1, 0, 1'b0, 0};
        vecs[3]  = '{12, -1, 32'h0000_0000, -1, -1, 8, 1'b0, 10};
        vecs[4]  = '{8,   2, 32'h0000_0000, -1, -1, 1, 1'b0, 4};
        vecs[5]  = '{1,  -1, 32'h0000_0000, -1, -1, 1, 1'b0, 3};
        vecs[6]  = '{8,   1, 32'h0000_0000, -1, -1, 0, 1'b0, 3};
        vecs[7]  = '{3,  -1, 32'h0000_000A, -1, -1, 1, 1'b1, 5};
        vecs[8]  = '{4,  -1, 32'h0000_0000, -1,  2, 4, 1'b0, 6};
        vecs[9]  = '{2,  -1, 32'h0000_0000, -1,  5, 4, 1'b0, 8};
        vecs[10] = '{2,  -1, 32'h0000_0000, -1,  4, 2, 1'b0, 4};
        vecs[11] = '{4,  -1, 32'h0000_0004,  2, -1, 3, 1'b1, 6};
        vecs[12] = '{2,  -1, 32'h0000_0002,  4, -1, 1, 1'b0, 4};
        vecs[13] = '{4,   2, 32'h0000_0004, -1, -1, 1, 1'b0, 4};

        // Asynchronous reset while idle: outputs must settle before any clock edge.
        #2 RESET_N = 1'b0;
        #1;
        checkOutput("rst_dm", DSIZE'(DM), DSIZE'(4'hF));
        checkOutput("rst_datain", DATAIN, '0);
        checkOutput("rst_dq_oe", DSIZE'(DQ_OE), '0);
        checkOutput("rst_fifo_rd", DSIZE'(FIFO_RD), '0);
        checkOutput("rst_busy", DSIZE'(BUSY), '0);
        checkOutput("rst_underrun", DSIZE'(UNDERRUN), '0);
        tick();
        tick();
        RESET_N = 1'b1;
        tick();

        for (int v = 0; v < NVEC; v++) begin
            prepVector(12, 1'b0);
            applyStimulus(vecs[v].len, vecs[v].abort_at, vecs[v].mask,
                          vecs[v].clr_at, vecs[v].restart_at);
            rd_n   = 0;
            busy_n = 0;
            for (int r = 0; r < NWIN; r++) begin
                if (rec_rd[r])   rd_n++;
                if (rec_busy[r]) busy_n++;
            end
            checkOutput($sformatf("v%0d_rd_count", v), rd_n, vecs[v].exp_rd);
            checkOutput($sformatf("v%0d_busy_cycles", v), busy_n, vecs[v].exp_busy);
            checkOutput($sformatf("v%0d_underrun", v), DSIZE'(rec_und[NWIN-1]), DSIZE'(vecs[v].exp_und));
            checkOutput($sformatf("v%0d_idle_oe", v), DSIZE'(rec_oe[NWIN-1]), '0);
            checkOutput($sformatf("v%0d_idle_dm", v), DSIZE'(rec_dm[NWIN-1]), DSIZE'(4'hF));
        end

        // Full burst of A0..A3: exact cycle alignment of FIFO_RD, DM, DATAIN, DQ_OE, BUSY.
        prepVector(4, 1'b1);
        applyStimulus(4, -1, 32'h0, -1, -1);
        for (int r = 0; r < 9; r++) begin
            exp_oe = (r >= 3 && r <= 6);
            checkOutput($sformatf("full_rd_r%0d", r), DSIZE'(rec_rd[r]), DSIZE'(r >= 1 && r <= 4));
            checkOutput($sformatf("full_dm_r%0d", r), DSIZE'(rec_dm[r]),
                        (r >= 2 && r <= 5) ? '0 : DSIZE'(4'hF));
            checkOutput($sformatf("full_oe_r%0d", r), DSIZE'(rec_oe[r]), DSIZE'(exp_oe));
            checkOutput($sformatf("full_data_r%0d", r), rec_data[r], exp_oe ? a_words[r-3] : '0);
            checkOutput($sformatf("full_busy_r%0d", r), DSIZE'(rec_busy[r]), DSIZE'(r >= 1 && r <= 6));
        end

        // Underrun on beat 1: masked slot, sticky flag, remaining words shift to later beats.
        prepVector(4, 1'b1);
        applyStimulus(4, -1, 32'h4, -1, -1);
        checkOutput("und_rd_r1", DSIZE'(rec_rd[1]), 1);
        checkOutput("und_rd_r2", DSIZE'(rec_rd[2]), 0);
        checkOutput("und_rd_r3", DSIZE'(rec_rd[3]), 1);
        checkOutput("und_dm_r2", DSIZE'(rec_dm[2]), 0);
        checkOutput("und_dm_r3", DSIZE'(rec_dm[3]), DSIZE'(4'hF));
        checkOutput("und_oe_r4", DSIZE'(rec_oe[4]), 1);
        checkOutput("und_data_r4", rec_data[4], '0);
        checkOutput("und_flag_r2", DSIZE'(rec_und[2]), 0);
        checkOutput("und_flag_r3", DSIZE'(rec_und[3]), 1);
        checkOutput("und_data_r3", rec_data[3], a_words[0]);
        checkOutput("und_data_r5", rec_data[5], a_words[1]);
        checkOutput("und_data_r6", rec_data[6], a_words[2]);
        checkOutput("und_sticky", DSIZE'(rec_und[NWIN-1]), 1);

        // Clear coinciding with a fresh underrun: the set wins.
        applyStimulus(1, -1, 32'h2, 1, -1);
        checkOutput("und_set_wins", DSIZE'(rec_und[2]), 1);
        applyStimulus(0, -1, 32'h0, 0, -1);
        checkOutput("und_before_clr", DSIZE'(rec_und[0]), 1);
        checkOutput("und_after_clr", DSIZE'(rec_und[1]), 0);

        // Reset asserted in the middle of an 8-beat burst.
        prepVector(12, 1'b0);
        WR_START = 1'b1;
        WR_LEN   = CNT_W'(8);
        tick();
        WR_START = 1'b0;
        WR_LEN   = '0;
        tick();
        tick();
        checkOutput("midrst_pre_oe", DSIZE'(DQ_OE), 1);
        checkOutput("midrst_pre_busy", DSIZE'(BUSY), 1);
        RESET_N = 1'b0;
        #1;
        checkOutput("midrst_dm", DSIZE'(DM), DSIZE'(4'hF));
        checkOutput("midrst_datain", DATAIN, '0);
        checkOutput("midrst_dq_oe", DSIZE'(DQ_OE), 0);
        checkOutput("midrst_fifo_rd", DSIZE'(FIFO_RD), 0);
        checkOutput("midrst_busy", DSIZE'(BUSY), 0);
        tick();
        RESET_N = 1'b1;
        for (int r = 0; r < 6; r++) begin
            tick();
            checkOutput($sformatf("postrst_rd_r%0d", r), DSIZE'(s_rd), 0);
            checkOutput($sformatf("postrst_oe_r%0d", r), DSIZE'(s_oe), 0);
            checkOutput($sformatf("postrst_busy_r%0d", r), DSIZE'(s_busy), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
